// File: rtl/aes_pkg.sv
// Shared Rijndael geometry helpers for the ShiftRows stream unit.
// Covers legal state widths, per-row rotation and byte positions in the packed state.
package aes_pkg;

   function automatic bit nb_legal(int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   // Rotation amount of a row; the 256-bit block skips offset 2.
   function automatic int shift_off(int nb, int row);
      if ((nb == 8) && (row >= 2)) return row + 1;
      return row;
   endfunction

   // LSB position of state byte (row, col); byte 0 is the most significant.
   function automatic int byte_lsb(int nb, int row, int col);
      return 32 * nb - 8 - 8 * (row + 4 * col);
   endfunction

   function automatic int blk_w(int nb);
      return 32 * nb;
   endfunction

endpackage

// File: rtl/shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for NB-column states.
module shiftrows_perm
   import aes_pkg::*;
#(
   parameter int unsigned NB = 4
) (
   input  logic                inv,
   input  logic [32*NB-1:0]    din,
   output logic [32*NB-1:0]    dout
);

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int Off  = shift_off(NB, r);
         localparam int SrcF = (c + Off) % NB;
         localparam int SrcI = (c + NB - Off) % NB;
         assign dout[byte_lsb(NB, r, c) +: 8] = inv ? din[byte_lsb(NB, r, SrcI) +: 8]
                                                    : din[byte_lsb(NB, r, SrcF) +: 8];
      end
   end

endmodule

// File: rtl/shiftrows_stream.sv
// Streaming ShiftRows unit: permutes on accept and queues data, tag and sequence number
// in a small output FIFO with valid/ready on both sides.
module shiftrows_stream
   import aes_pkg::*;
#(
   parameter int unsigned NB    = 4,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned TAG_W = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [32*NB-1:0]           in_data,
   input  logic                       in_inv,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [32*NB-1:0]           out_data,
   output logic [TAG_W-1:0]           out_tag,
   output logic [15:0]                out_seq,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int W  = blk_w(NB);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   if (!nb_legal(NB)) begin : g_bad_nb
      $error("shiftrows_stream: NB must be 4, 6 or 8");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("shiftrows_stream: DEPTH must be a power of two >= 2");
   end

   typedef struct packed {
      logic [W-1:0]     data;
      logic [TAG_W-1:0] tag;
      logic [15:0]      seq;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [OW-1:0]   count_q;
   logic [15:0]     seq_q;
   logic            rdy_q;
   logic [W-1:0]    perm_data;
   logic            push, pop;

   shiftrows_perm #(
      .NB (NB)
   ) u_perm (
      .inv  (in_inv),
      .din  (in_data),
      .dout (perm_data)
   );

   // rdy_q holds in_ready low during reset and releases it on the first edge afterwards.
   assign in_ready  = rdy_q && (count_q < OW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign occupancy = count_q;
   assign out_data  = mem_q[rptr_q].data;
   assign out_tag   = mem_q[rptr_q].tag;
   assign out_seq   = mem_q[rptr_q].seq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         seq_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (push) begin
            mem_q[wptr_q] <= '{data: perm_data, tag: in_tag, seq: seq_q};
            wptr_q        <= wptr_q + AW'(1);
            seq_q         <= seq_q + 16'd1;
         end
         if (pop) rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + OW'(push) - OW'(pop);
      end
   end

endmodule

// File: tb/tb_shiftrows_stream.sv
// Self-checking bench for shiftrows_stream: directed vectors, randomized traffic against a
// row-rotation reference model with a queue-based FIFO, backpressure, sequence wrap and reset.
module tb_shiftrows_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         v4 = 0, r4, inv4 = 0, ov4, ordy4 = 0;
   logic [127:0] d4 = '0, od4;
   logic [3:0]   tag4 = '0, ot4;
   logic [15:0]  os4;
   logic [1:0]   occ4;

   logic         v8 = 0, r8, inv8 = 0, ov8, ordy8 = 1;
   logic [255:0] d8 = '0, od8;
   logic [3:0]   tag8 = '0, ot8;
   logic [15:0]  os8;
   logic [1:0]   occ8;

   shiftrows_stream #(.NB(4), .DEPTH(2), .TAG_W(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4), .in_inv(inv4),
      .in_tag(tag4), .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_tag(ot4),
      .out_seq(os4), .occupancy(occ4)
   );

   shiftrows_stream #(.NB(8), .DEPTH(2), .TAG_W(4)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_data(d8), .in_inv(inv8),
      .in_tag(tag8), .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_tag(ot8),
      .out_seq(os8), .occupancy(occ8)
   );

   typedef struct {
      logic [127:0] data;
      logic [3:0]   tag;
      logic [15:0]  seq;
   } ent_t;

   ent_t        q[$];
   logic [15:0] mseq = '0;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: split into rows, rotate each row as a list of bytes, reassemble.
   function automatic logic [255:0] ref_perm(int nb, logic [255:0] d, bit inv);
      logic [255:0] o = '0;
      logic [7:0]   row[$];
      int           off;
      for (int r = 0; r < 4; r++) begin
         row.delete();
         for (int c = 0; c < nb; c++) row.push_back(d[nb*32-1-8*(r+4*c) -: 8]);
         off = (nb == 8 && r >= 2) ? r + 1 : r;
         for (int k = 0; k < off; k++) begin
            if (!inv) row.push_back(row.pop_front());
            else      row.push_front(row.pop_back());
         end
         for (int c = 0; c < nb; c++) o[nb*32-1-8*(r+4*c) -: 8] = row[c];
      end
      return o;
   endfunction

   // One clock of the NB=4 unit with model update and full output comparison.
   task automatic cycle4();
      bit           acc, pp;
      ent_t         e;
      logic [255:0] p;
      chk("in_ready", 256'(r4), 256'(q.size() < 2));
      acc = v4 && (q.size() < 2);
      pp  = (q.size() != 0) && ordy4;
      @(posedge clk);
      if (pp) e = q.pop_front();
      if (acc) begin
         p      = ref_perm(4, {128'b0, d4}, inv4);
         e.data = p[127:0];
         e.tag  = tag4;
         e.seq  = mseq;
         q.push_back(e);
         mseq++;
      end
      #1;
      chk("occupancy", 256'(occ4), 256'(q.size()));
      chk("out_valid", 256'(ov4), 256'(q.size() != 0));
      if (q.size() != 0) begin
         chk("out_data", 256'(od4), 256'(q[0].data));
         chk("out_tag", 256'(ot4), 256'(q[0].tag));
         chk("out_seq", 256'(os4), 256'(q[0].seq));
      end
   endtask

   logic [127:0] vec, fwd_exp, inv_exp;
   logic [255:0] p8;
   logic [15:0]  prev_os;
   bit           wrapped;

   initial begin
      vec     = 128'h000102030405060708090a0b0c0d0e0f;
      fwd_exp = 128'h00050a0f04090e03080d02070c01060b;
      inv_exp = 128'h000d0a0704010e0b0805020f0c090603;

      #2;
      chk("rst_in_ready", 256'(r4), 256'(0));
      chk("rst_out_valid", 256'(ov4), 256'(0));
      chk("rst_occupancy", 256'(occ4), 256'(0));
      chk("rst_out_data", 256'(od4), 256'(0));
      chk("rst_out_seq", 256'(os4), 256'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("ready_before_edge", 256'(r4), 256'(0));
      @(posedge clk); #1;
      chk("ready_after_release", 256'(r4), 256'(1));

      // Directed NB=4 vectors
      ordy4 = 1; v4 = 1; d4 = vec; tag4 = 4'd3; inv4 = 0;
      cycle4();
      chk("fwd_vec", 256'(od4), 256'(fwd_exp));
      chk("fwd_tag", 256'(ot4), 256'(3));
      chk("fwd_seq", 256'(os4), 256'(0));
      inv4 = 1; tag4 = 4'd5;
      cycle4();
      chk("inv_vec", 256'(od4), 256'(inv_exp));
      d4 = fwd_exp;
      cycle4();
      chk("roundtrip", 256'(od4), 256'(vec));
      v4 = 0;
      cycle4();

      // NB=8 row offsets 0,1,3,4
      for (int i = 0; i < 32; i++) d8[255-8*i -: 8] = 8'(i);
      v8 = 1; tag8 = 4'd9;
      @(posedge clk); #1;
      v8 = 0;
      chk("nb8_valid", 256'(ov8), 256'(1));
      chk("nb8_col0", 256'(od8[255 -: 32]), 256'(32'h00050e13));
      p8 = ref_perm(8, d8, 1'b0);
      chk("nb8_full", od8, p8);
      chk("nb8_tag", 256'(ot8), 256'(9));

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         v4 = 1'($urandom_range(0, 1));
         d4 = {$urandom, $urandom, $urandom, $urandom};
         inv4 = 1'($urandom_range(0, 1));
         tag4 = 4'($urandom);
         ordy4 = 1'($urandom_range(0, 1));
         cycle4();
      end

      // Backpressure fill then drain
      v4 = 0; ordy4 = 1;
      cycle4(); cycle4();
      ordy4 = 0; v4 = 1;
      d4 = {$urandom, $urandom, $urandom, $urandom}; cycle4();
      d4 = {$urandom, $urandom, $urandom, $urandom}; cycle4();
      chk("bp_full_ready", 256'(r4), 256'(0));
      chk("bp_full_occ", 256'(occ4), 256'(2));
      cycle4();
      chk("bp_hold_occ", 256'(occ4), 256'(2));
      v4 = 0; ordy4 = 1;
      cycle4();
      chk("bp_ready_back", 256'(r4), 256'(1));
      cycle4();

      // Simultaneous push/pop at occupancy 1
      ordy4 = 0; v4 = 1; cycle4();
      ordy4 = 1; cycle4();
      chk("pushpop_occ", 256'(occ4), 256'(1));
      v4 = 0; cycle4();

      // Long stream to wrap the sequence counter
      v4 = 1; ordy4 = 1; wrapped = 0; prev_os = os4;
      for (int n = 0; n < 70000; n++) begin
         d4 = {$urandom, $urandom, $urandom, $urandom};
         inv4 = 1'($urandom_range(0, 1));
         cycle4();
         if (prev_os == 16'hffff && os4 == 16'h0000) wrapped = 1;
         prev_os = os4;
      end
      chk("seq_wrap_seen", 256'(wrapped), 256'(1));
      v4 = 0; cycle4(); cycle4();

      // Reset with two blocks queued
      ordy4 = 0; v4 = 1;
      cycle4(); cycle4();
      v4 = 0;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 256'(ov4), 256'(0));
      chk("midrst_occupancy", 256'(occ4), 256'(0));
      chk("midrst_in_ready", 256'(r4), 256'(0));
      q.delete(); mseq = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      ordy4 = 1; v4 = 1; d4 = vec; inv4 = 0; tag4 = 4'd7;
      cycle4();
      chk("seq_after_reset", 256'(os4), 256'(0));
      chk("data_after_reset", 256'(od4), 256'(fwd_exp));
      v4 = 0; cycle4();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shiftrows_stream.md
# shiftrows_stream

Streaming, parametrised Rijndael ShiftRows/InvShiftRows unit with valid/ready handshake and an output FIFO, for the looped and unrolled round datapaths. It generalises the fixed 128-bit combinational ShiftRows to block widths of 128, 192 and 256 bits (NB = 4, 6, 8 columns) and selects direction per block. A tag travels with each block so round or key-schedule context stays aligned. Each accepted block gets a per-block sequence number.

## Interface
- NB, 4, state columns; legal values 4, 6, 8; anything else fails elaboration
- DEPTH, 2, output FIFO entries; power of two, ≥ 2
- TAG_W, 4, width of sideband tag
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input block valid
- in_ready  out  1  unit can accept a block
- in_data  in  32*NB  state; byte i at bits [32*NB-1-8i -: 8], i = row + 4*col (column-major)
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output block valid
- out_ready  in  1  downstream accepts
- out_data  out  32*NB  permuted state
- out_tag  out  TAG_W  tag of the output block
- out_seq  out  16  sequence number of the output block
- occupancy  out  $clog2(DEPTH)+1  FIFO fill level

## Operation
- Row offsets s_r: rows 0..3 = 0,1,2,3 for NB = 4 and 6; 0,1,3,4 for NB = 8.
- Forward: out[r][c] = in[r][(c + s_r) mod NB]. Inverse: out[r][c] = in[r][(c − s_r) mod NB].
- Permutation is combinational on the input side. The permuted data, tag and the sequence count are written into the FIFO on accept (in_valid & in_ready).
- in_ready = (occupancy < DEPTH), computed from registered state only. No flow-through when full, even if out_ready = 1 that cycle.
- Pop on out_valid & out_ready. Push and pop in the same cycle: occupancy unchanged; both pointers advance.
- out_valid = (occupancy != 0). out_data, out_tag and out_seq come from the head entry and are held stable while out_valid & !out_ready.
- Sequence counter: 16-bit, increments on every accept, wraps 0xFFFF → 0x0000.
- in_inv is sampled per block; mixed directions back-to-back are legal.

## Timing
- Latency: block accepted at edge t is visible on out_valid/out_data after edge t (cycle t+1). The output side is not a combinational path from the inputs.
- Throughput: one block per cycle while out_ready stays high.
- Reset (rst_n low, any time, including mid-stream): in_ready = 0 while rst_n is low. After release: occupancy = 0, out_valid = 0, sequence counter = 0, pointers = 0, out_data/out_tag/out_seq = 0. Any in-flight blocks are discarded. in_ready = 1 on the first clock edge after rst_n rises.
- FIFO full: in_ready = 0 until a pop occurs. Empty: out_valid = 0; out_data holds its last value (don't-care).

## Structure
- Package aes_pkg: NB legality check, function shift_off(nb, row), byte-index helper, block-width constant 32*NB.
- Sub-module shiftrows_perm (NB parameter, purely combinational, fwd/inv select). The top module holds the FIFO, counters and handshake.

## Test plan
- NB=4, fwd, in = 0x000102030405060708090a0b0c0d0e0f, tag 3 → next cycle out = 0x00050a0f04090e03080d02070c01060b, out_tag 3, out_seq 0.
- NB=4, inv, same input → out = 0x000d0a0704010e0b0805020f0c090603. Feeding the forward result back with inv=1 returns the original input.
- NB=8, fwd, byte i = i for i = 0..31 → first output column = 00 05 0e 13. This checks row offsets 0,1,3,4.
- Backpressure: out_ready = 0, push DEPTH blocks → in_ready drops after the DEPTH-th accept. Set out_ready = 1 → blocks exit in order with seq 0..DEPTH−1. in_ready returns the cycle after the first pop.
- Simultaneous push/pop at occupancy 1 → occupancy stays 1. Streaming 70000 blocks → out_seq wraps 0xFFFF → 0x0000.
- Assert rst_n low with 2 blocks queued → out_valid = 0 and occupancy = 0 immediately. After release, the next block carries seq 0.
